// File: rtl/packer_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one data_packer between NUM_SRC AXI-Stream sources.
// Optional length guard: define PKT_LEN_GUARD_EN to force tlast at the configured length and add err_overlen.
module packer_stream_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_wr_en,
    input  logic [SEL_W-1:0]              cfg_wr_sel,
    input  logic [15:0]                   cfg_wr_data,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [15:0]                   confi,
`ifdef PKT_LEN_GUARD_EN
    output logic                          err_overlen,
`endif
    output logic [NUM_SRC-1:0]            grant,
    output logic                          busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOCK = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;

    logic [1:0]            r_state;
    logic [15:0]           r_table [NUM_SRC];
    logic [SEL_W-1:0]      r_rr_last;
    logic [SEL_W-1:0]      r_owner;
    logic [15:0]           r_cand_confi;
    logic [15:0]           r_confi;
    logic [NUM_SRC-1:0]    r_grant;

    logic                  w_found;
    logic [SEL_W-1:0]      w_winner;
    logic [DATA_WIDTH-1:0] w_src_data;
    logic                  w_src_valid;
    logic                  w_src_last;
    logic                  w_in_pass;
    logic                  w_accept;
    logic                  w_end_pkt;
    logic                  w_force_last;

    // Indices >= NUM_SRC match no entry, so out-of-range writes fall away.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (reset)
                r_table[i] <= 16'h0000;
            else if (cfg_wr_en && (cfg_wr_sel == SEL_W'(i)))
                r_table[i] <= cfg_wr_data;
        end
    end

    // Two passes: indices above the pointer first, then wrap to the rest.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && s_axis_tvalid[i] && (SEL_W'(i) > r_rr_last)) begin
                w_found  = 1'b1;
                w_winner = SEL_W'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && s_axis_tvalid[i] && (SEL_W'(i) <= r_rr_last)) begin
                w_found  = 1'b1;
                w_winner = SEL_W'(i);
            end
        end
    end

    always_comb begin
        w_src_data  = '0;
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant[i]) begin
                w_src_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_src_valid = s_axis_tvalid[i];
                w_src_last  = s_axis_tlast[i];
            end
        end
    end

    assign w_in_pass = (r_state == ST_PASS);
    assign w_accept  = w_in_pass & w_src_valid & m_axis_tready;
    assign w_end_pkt = w_accept & m_axis_tlast;

`ifdef PKT_LEN_GUARD_EN
    logic [7:0] r_beat_cnt;
    logic       r_err_overlen;

    // Fires on the beat that reaches the configured length without the source's own tlast.
    assign w_force_last = (r_confi[7:0] != 8'd0) && ((r_beat_cnt + 8'd1) == r_confi[7:0]) && !w_src_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_cnt    <= 8'd0;
            r_err_overlen <= 1'b0;
        end else begin
            if (r_state == ST_LOCK)
                r_beat_cnt <= 8'd0;
            else if (w_accept)
                r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_accept && w_force_last)
                r_err_overlen <= 1'b1;
        end
    end

    assign err_overlen = r_err_overlen;
`else
    assign w_force_last = 1'b0;
`endif

    // The table value is captured at the pick edge so a same-cycle write waits for the next packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_confi      <= 16'h0000;
            r_rr_last    <= SEL_W'(NUM_SRC - 1);
            r_owner      <= '0;
            r_cand_confi <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner      <= w_winner;
                        r_cand_confi <= r_table[w_winner];
                        r_state      <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    r_confi   <= r_cand_confi;
                    r_grant   <= NUM_SRC'(1) << r_owner;
                    r_rr_last <= r_owner;
                    r_state   <= ST_PASS;
                end
                ST_PASS: begin
                    if (w_end_pkt) begin
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
        assign s_axis_tready[gi] = r_grant[gi] & m_axis_tready & w_in_pass;
    end

    assign m_axis_tdata  = w_src_data;
    assign m_axis_tvalid = w_in_pass & w_src_valid;
    assign m_axis_tlast  = w_in_pass & w_src_valid & (w_src_last | w_force_last);
    assign confi         = r_confi;
    assign grant         = r_grant;
    assign busy          = (r_state == ST_LOCK) || (r_state == ST_PASS);

endmodule
